// File: rtl/keypad_event_scanner_pkg.sv
// Shared types and event-code helpers for the keypad event scanner.
package keypad_pkg;

  typedef enum logic [0:0] {
    ST_SCAN   = 1'b0,
    ST_COMMIT = 1'b1
  } scan_state_e;

  localparam int EV_CODE_W   = 8;
  localparam int EV_PRESS_BIT = 7;
  localparam int EV_INDEX_W  = 7;

  function automatic logic [EV_CODE_W-1:0] ev_make(input logic press,
                                                   input logic [EV_INDEX_W-1:0] idx);
    logic [EV_CODE_W-1:0] code;
    code = '0;
    code[EV_PRESS_BIT] = press;
    code[EV_INDEX_W-1:0] = idx;
    return code;
  endfunction

  function automatic logic ev_is_press(input logic [EV_CODE_W-1:0] code);
    return code[EV_PRESS_BIT];
  endfunction

  function automatic logic [EV_INDEX_W-1:0] ev_index(input logic [EV_CODE_W-1:0] code);
    return code[EV_INDEX_W-1:0];
  endfunction

endpackage

// File: rtl/keypad_event_scanner_if.sv
// Event stream from the keypad scanner: FWFT head with valid/ready pop plus sticky overflow.
interface keypad_event_scanner_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       overflow;

  modport master (output ev_valid, output ev_code, output overflow, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input overflow, output ev_ready);
endinterface

// File: rtl/keypad_event_scanner_fifo.sv
// key_event_fifo: 8-bit first-word-fall-through FIFO with valid/ready pop and sticky overflow.
module key_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        ovf_q, ovf_d;
  logic        empty, full, pop, do_push;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full || pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (pop)     rd_d = rd_q + 1'b1;
    if (push_i && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: active-low row strobes, per-frame debounce, press/release event FIFO.
// Define KEYPAD_RELEASE_EV_EN to queue release events too; by default only presses are queued.
module keypad_event_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic [COLS-1:0]      cols,
  output logic [ROWS-1:0]      rows,
  output logic [ROWS*COLS-1:0] key_state,
  keypad_event_scanner_if.master ev
);
  localparam int NKEYS = ROWS * COLS;
  localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW    = (NKEYS > 1) ? $clog2(NKEYS) : 1;

  scan_state_e          state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [KW-1:0]        key_q, key_d;
  logic [ROWS-1:0]      rows_q, rows_d;
  logic [NKEYS-1:0]     key_state_q, key_state_d;
  logic [NKEYS-1:0]     raw_q, raw_d;
  logic [3:0]           cnt_q [NKEYS];
  logic [3:0]           cnt_d [NKEYS];
  logic [COLS-1:0]      cols_meta_q, cols_sync_q;
  logic                 ev_push;
  logic [EV_CODE_W-1:0] ev_push_code;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    dwell_d      = dwell_q;
    key_d        = key_q;
    rows_d       = '1;
    key_state_d  = key_state_q;
    raw_d        = raw_q;
    cnt_d        = cnt_q;
    ev_push      = 1'b0;
    ev_push_code = '0;
    unique case (state_q)
      ST_SCAN: begin
        rows_d = ~(ROWS'(1) << row_q);
        if (dwell_q == DW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          raw_d[int'(row_q)*COLS +: COLS] = ~cols_sync_q;
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            key_d   = '0;
            state_d = ST_COMMIT;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (raw_q[key_q] == key_state_q[key_q]) begin
          cnt_d[key_q] = '0;
        end else if (cnt_q[key_q] + 4'd1 == 4'(DEBOUNCE)) begin
          cnt_d[key_q]       = '0;
          key_state_d[key_q] = raw_q[key_q];
          ev_push_code       = ev_make(raw_q[key_q], EV_INDEX_W'(key_q));
`ifdef KEYPAD_RELEASE_EV_EN
          ev_push = 1'b1;
`else
          ev_push = raw_q[key_q];
`endif
        end else begin
          cnt_d[key_q] = cnt_q[key_q] + 4'd1;
        end
        if (key_q == KW'(NKEYS - 1)) begin
          state_d = ST_SCAN;
        end else begin
          key_d = key_q + 1'b1;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Row strobes are registered from the current scan position, so each row's low
  // window trails its dwell count by one cycle and the synchroniser has settled by the sample.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      row_q       <= '0;
      dwell_q     <= '0;
      key_q       <= '0;
      rows_q      <= '1;
      key_state_q <= '0;
      for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      key_q       <= key_d;
      rows_q      <= rows_d;
      key_state_q <= key_state_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    cols_meta_q <= cols;
    cols_sync_q <= cols_meta_q;
    raw_q       <= raw_d;
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLOCK_50),
    .rst        (rst),
    .push_i     (ev_push),
    .data_i     (ev_push_code),
    .ready_i    (ev.ev_ready),
    .valid_o    (ev.ev_valid),
    .data_o     (ev.ev_code),
    .overflow_o (ev.overflow)
  );

  assign rows      = rows_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Self-checking bench for keypad_event_scanner: keypad matrix model, step table and event scoreboard.
module tb_keypad_event_scanner;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 2, FIFO_DEPTH = 4;
  localparam int NK = ROWS * COLS;
`ifdef KEYPAD_RELEASE_EV_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [COLS-1:0] cols;
  logic [ROWS-1:0] rows;
  logic [NK-1:0] key_state;
  logic [NK-1:0] keys = '0;

  keypad_event_scanner_if ev_if ();

  keypad_event_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .CLOCK_50  (clk),
    .rst       (rst),
    .cols      (cols),
    .rows      (rows),
    .key_state (key_state),
    .ev        (ev_if)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its row strobe onto its column line.
  always_comb begin
    cols = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!rows[r] && keys[r*COLS+c]) cols[c] = 1'b0;
  end

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h, expected no event", ev_if.ev_code);
      end else begin
        check("ev_code", {24'h0, ev_if.ev_code}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_frame_start();
    logic [ROWS-1:0] prev;
    prev = rows;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (prev == 4'b1111 && rows == 4'b1110) return;
      prev = rows;
    end
    checks++;
    errors++;
    $display("FAIL frame_sync: rows=%b, expected a frame start within 200 cycles", rows);
  endtask

  task automatic check_scan_start();
    for (int i = 0; i < SCAN_DIV; i++) begin
      @(negedge clk);
      check("rows_row0", {28'h0, rows}, 32'h0000_000E);
    end
    @(negedge clk);
    check("rows_row1", {28'h0, rows}, 32'h0000_000D);
  endtask

  typedef struct packed {
    logic [15:0] keys;
    logic [3:0]  frames;
    logic [15:0] exp_state;
    logic [1:0]  n_ev;
    logic [7:0]  ev0;
    logic [7:0]  ev1;
  } step_t;

  step_t tbl [10];

  initial begin
    int seen;
    tbl[0] = '{keys: 16'h0040, frames: 4'd3, exp_state: 16'h0040, n_ev: 2'd1, ev0: 8'h86, ev1: 8'h00};
    tbl[1] = '{keys: 16'h0040, frames: 4'd1, exp_state: 16'h0040, n_ev: 2'd0, ev0: 8'h00, ev1: 8'h00};
    tbl[2] = '{keys: 16'h0000, frames: 4'd3, exp_state: 16'h0000, n_ev: REL_EN ? 2'd1 : 2'd0, ev0: 8'h06, ev1: 8'h00};
    tbl[3] = '{keys: 16'h0001, frames: 4'd1, exp_state: 16'h0000, n_ev: 2'd0, ev0: 8'h00, ev1: 8'h00};
    tbl[4] = '{keys: 16'h0000, frames: 4'd3, exp_state: 16'h0000, n_ev: 2'd0, ev0: 8'h00, ev1: 8'h00};
    tbl[5] = '{keys: 16'h8001, frames: 4'd3, exp_state: 16'h8001, n_ev: 2'd2, ev0: 8'h80, ev1: 8'h8F};
    tbl[6] = '{keys: 16'h0000, frames: 4'd3, exp_state: 16'h0000, n_ev: REL_EN ? 2'd2 : 2'd0, ev0: 8'h00, ev1: 8'h0F};
    tbl[7] = '{keys: 16'h0400, frames: 4'd1, exp_state: 16'h0000, n_ev: 2'd0, ev0: 8'h00, ev1: 8'h00};
    tbl[8] = '{keys: 16'h0400, frames: 4'd1, exp_state: 16'h0400, n_ev: 2'd1, ev0: 8'h8A, ev1: 8'h00};
    tbl[9] = '{keys: 16'h0000, frames: 4'd3, exp_state: 16'h0000, n_ev: REL_EN ? 2'd1 : 2'd0, ev0: 8'h0A, ev1: 8'h00};

    ev_if.ev_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rows", {28'h0, rows}, 32'h0000_000F);
    check("rst_ev_valid", {31'h0, ev_if.ev_valid}, 32'h0);
    check("rst_ev_code", {24'h0, ev_if.ev_code}, 32'h0);
    check("rst_key_state", {16'h0, key_state}, 32'h0);
    check("rst_overflow", {31'h0, ev_if.overflow}, 32'h0);
    rst = 1'b0;
    check_scan_start();

    wait_frame_start();
    for (int i = 0; i < 10; i++) begin
      keys = tbl[i].keys;
      if (tbl[i].n_ev >= 2'd1) exp_q.push_back(tbl[i].ev0);
      if (tbl[i].n_ev >= 2'd2) exp_q.push_back(tbl[i].ev1);
      repeat (int'(tbl[i].frames)) wait_frame_start();
      check($sformatf("step%0d_key_state", i), {16'h0, key_state}, {16'h0, tbl[i].exp_state});
      check($sformatf("step%0d_events_left", i), exp_q.size(), 32'h0);
    end

    // Six simultaneous presses into a stalled 4-deep FIFO.
    ev_if.ev_ready = 1'b0;
    keys = 16'h003F;
    for (int k = 0; k < FIFO_DEPTH; k++) exp_q.push_back(8'h80 + 8'(k));
    repeat (2) wait_frame_start();
    check("ovf_overflow", {31'h0, ev_if.overflow}, 32'h1);
    check("ovf_key_state", {16'h0, key_state}, 32'h0000_003F);
    check("ovf_ev_valid", {31'h0, ev_if.ev_valid}, 32'h1);
    check("ovf_head", {24'h0, ev_if.ev_code}, 32'h80);
    ev_if.ev_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("ovf_drained", exp_q.size(), 32'h0);
    check("ovf_empty_valid", {31'h0, ev_if.ev_valid}, 32'h0);
    check("ovf_empty_code", {24'h0, ev_if.ev_code}, 32'h0);
    wait_frame_start();
    keys = '0;
    if (REL_EN) for (int k = 0; k < 6; k++) exp_q.push_back(8'(k));
    repeat (3) wait_frame_start();
    check("rel_key_state", {16'h0, key_state}, 32'h0);
    check("rel_events_left", exp_q.size(), 32'h0);
    check("ovf_sticky", {31'h0, ev_if.overflow}, 32'h1);

    // Reset in the middle of COMMIT with two events queued.
    ev_if.ev_ready = 1'b0;
    keys = 16'h0003;
    wait_frame_start();
    seen = 0;
    for (int n = 0; n < 100 && seen == 0; n++) begin
      @(negedge clk);
      if (rows == 4'b1111) seen = 1;
    end
    check("commit_reached", seen, 32'h1);
    @(negedge clk);
    check("pre_rst_valid", {31'h0, ev_if.ev_valid}, 32'h1);
    check("pre_rst_head", {24'h0, ev_if.ev_code}, 32'h80);
    check("pre_rst_key_state", {16'h0, key_state}, 32'h0000_0003);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ev_valid", {31'h0, ev_if.ev_valid}, 32'h0);
    check("midrst_ev_code", {24'h0, ev_if.ev_code}, 32'h0);
    check("midrst_key_state", {16'h0, key_state}, 32'h0);
    check("midrst_overflow", {31'h0, ev_if.overflow}, 32'h0);
    check("midrst_rows", {28'h0, rows}, 32'h0000_000F);
    keys = '0;
    ev_if.ev_ready = 1'b1;
    rst = 1'b0;
    check_scan_start();
    check("post_rst_ev_valid", {31'h0, ev_if.ev_valid}, 32'h0);
    check("final_events_left", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/keypad_event_scanner.md
# keypad_event_scanner

Parametrised matrix-keypad scanner for the FPGA front panel: drives ROWS active-low row strobes, samples COLS active-low column inputs, debounces every key per full scan frame, and queues press/release events into a small FIFO read with a valid/ready handshake. It replaces the fixed 4x4 keycode scanner feeding the LED/keycode path and exports a debounced key-state bitmap alongside the event stream.

## Interface
- ROWS, 4, number of row strobes (1..16)
- COLS, 4, number of column inputs (1..16); ROWS*COLS ≤ 128
- SCAN_DIV, 50000, clock cycles each row is held low (≥4)
- DEBOUNCE, 4, consecutive frames a raw key must disagree with its stable state before toggling (1..15)
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2)

- CLOCK_50  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cols  in  COLS  column inputs, active-low (pulled up externally), asynchronous
- rows  out  ROWS  row strobes, active-low, at most one low at a time
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_code  out  8  bit7 = 1 press / 0 release; bits6:0 = key index row*COLS+col
- overflow  out  1  sticky: an event was dropped
- key_state  out  ROWS*COLS  debounced state, 1 = pressed, bit = key index

## Operation
- Reset values: rows all 1, ev_valid 0, ev_code 0, overflow 0, key_state 0, debounce counters 0, FIFO empty, FSM in SCAN at row 0, dwell counter 0.
- cols passes through a 2-flop synchroniser before use.
- FSM states: SCAN, COMMIT.
- SCAN: row r driven low for SCAN_DIV cycles; on the last dwell cycle the synchronised, inverted cols are written into raw[r*COLS +: COLS]; then r increments. After row ROWS-1 → COMMIT.
- COMMIT: rows all 1; iterates key index k = 0..ROWS*COLS-1, one per cycle. If raw[k] == key_state[k], counter[k] ← 0. Else counter[k] increments; when it reaches DEBOUNCE, key_state[k] toggles, counter[k] ← 0, and an event {new state, k} is pushed. After last k → SCAN row 0.
- FIFO: first-word-fall-through; pop when ev_valid && ev_ready. Push while full and no pop in same cycle: event dropped, overflow ← 1 (held until rst). Push and pop in same cycle while full: both succeed. Push while empty: ev_valid rises next cycle.
- ev_code holds the head entry while ev_valid; 0 when empty.
- Dropped events still update key_state.

## Timing
- Frame length = ROWS*SCAN_DIV + ROWS*COLS cycles.
- Column sample latency: 2 cycles synchroniser; input must be stable ≥3 cycles before the dwell’s last cycle.
- Press-to-event: DEBOUNCE frames of agreement, event pushed in that frame’s COMMIT cycle k, ev_valid/ev_code update the following cycle, key_state updates the same edge as push.
- Counter widths: dwell $clog2(SCAN_DIV), row $clog2(ROWS), debounce 4 bits, FIFO pointers $clog2(FIFO_DEPTH)+1.
- rst asserted mid-frame or mid-COMMIT returns to reset values on the next edge; pending FIFO contents discarded.

## Configuration
- KEYPAD_RELEASE_EV_EN defined: release events (bit7 = 0) are pushed as above.
- Not defined: only press events are pushed; release transitions still update key_state and clear the counter, without FIFO push or overflow effect.

## Structure
- Package keypad_pkg: FSM state enum, EV_PRESS_BIT = 7, EV_INDEX_W = 7, event field helpers.
- Sub-module key_event_fifo (8-bit, FIFO_DEPTH, FWFT, valid/ready pop, full/overflow flag); scanner FSM, synchroniser and debounce in the top.

## Test plan
Bench parameters: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4, ev_ready=1 unless stated.
- Reset: rst high 3 cycles -> rows=4'b1111, ev_valid=0, key_state=0, overflow=0; after release, rows=4'b1110 for 4 cycles then 4'b1101.
- Press key row1/col2 held 3 frames -> exactly one ev_code=8'h86, key_state bit6=1 after second frame’s COMMIT.
- 1-frame glitch on row0/col0 -> no event, key_state stays 0.
- Release key 6 after stable press -> ev_code=8'h06 with macro; no event without macro, key_state bit6→0 in both.
- ev_ready=0, press keys 0–5 simultaneously -> FIFO holds 8'h80..8'h83 in order, overflow=1, key_state[5:0]=6'h3F.
- rst asserted during COMMIT with 2 queued events -> ev_valid=0 next cycle, FIFO empty, scan restarts at row 0.
